// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// default widths and a small state-classification helper.
package fetch_pkg;

  localparam int PC_W_DEF        = 16;
  localparam int PC_INC_DEF      = 2;
  localparam int ACK_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // True in the states where a memory read is outstanding.
  function automatic logic awaits_ack(input fetch_state_e s);
    return (s == ST_REQ) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive cycles spent waiting for a memory acknowledge and flags
// the cycle in which the wait reaches ACK_TIMEOUT.
module fetch_timeout_counter
  import fetch_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_inc;

  assign w_count_inc = r_count + CNT_W'(1);

  // Terminal flag fires on the waiting cycle that would make the count reach the limit.
  assign o_term = i_en && (w_count_inc == CNT_W'(ACK_TIMEOUT));

  // Wait-cycle counter with clear taking priority over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_en) begin
      r_count <= w_count_inc;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch sequencer: drives the PC register write port, issues instruction reads
// at the current PC and holds each fetched word until decode accepts it.
module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int PC_INC      = PC_INC_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] i_pc_cur,
  output logic [PC_W-1:0] o_pc_next,
  output logic            o_pc_write,
  output logic            o_mem_req,
  output logic [PC_W-1:0] o_mem_addr,
  input  logic            i_mem_ack,
  input  logic [PC_W-1:0] i_mem_rdata,
  output logic [PC_W-1:0] o_instr_out,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_target,
  input  logic            i_halt,
  output logic            o_fetch_fault
);

  localparam logic [PC_W-1:0] LP_PC_INC = PC_W'(PC_INC);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [PC_W-1:0] r_instr;
  logic            r_valid;
  logic            r_fault;

  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;
  logic            w_pc_write;
  logic            w_capture;
  logic            w_drop_valid;
  logic            w_set_fault;
  logic            w_waiting;
  logic            w_term;

  // Natural wrap at 2^PC_W gives FFFE -> 0000 for free.
  assign w_pc_inc  = i_pc_cur + LP_PC_INC;
  assign w_waiting = awaits_ack(r_state) && !i_mem_ack;

  fetch_timeout_counter #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (!w_waiting),
    .i_en   (w_waiting),
    .o_term (w_term)
  );

  // Next-state and PC write-port decode; redirect overrides the sequential path.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_next    = {PC_W{1'b0}};
    w_pc_write   = 1'b0;
    w_capture    = 1'b0;
    w_drop_valid = 1'b0;
    w_set_fault  = 1'b0;

    if (i_redirect) begin
      w_pc_write   = 1'b1;
      w_pc_next    = i_redirect_target;
      w_drop_valid = 1'b1;
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (i_halt || r_fault) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
        ST_REQ, ST_DRAIN: begin
          // An ack this cycle retires the old read; otherwise it is still in flight.
          if (i_mem_ack) begin
            w_state_nxt = ST_REQ;
          end else if (w_term) begin
            w_set_fault = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!i_halt && !r_fault) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (i_mem_ack) begin
            w_capture   = 1'b1;
            w_pc_write  = 1'b1;
            w_pc_next   = w_pc_inc;
            w_state_nxt = ST_HOLD;
          end else if (w_term) begin
            w_set_fault = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
        ST_HOLD: begin
          if (i_instr_ready) begin
            w_drop_valid = 1'b1;
            w_state_nxt  = i_halt ? ST_IDLE : ST_REQ;
          end else begin
            w_state_nxt  = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (i_mem_ack) begin
            w_state_nxt = ST_REQ;
          end else if (w_term) begin
            w_set_fault = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // The PC register clears itself on reset, so no write may reach it then.
    if (reset) begin
      w_pc_write = 1'b0;
    end else begin
      w_pc_write = w_pc_write;
    end
  end

  // State, held instruction and sticky fault registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_instr <= {PC_W{1'b0}};
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_instr <= i_mem_rdata;
        r_valid <= 1'b1;
      end else if (w_drop_valid) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      if (w_set_fault) begin
        r_fault <= 1'b1;
      end else begin
        r_fault <= r_fault;
      end
    end
  end

  assign o_pc_next     = w_pc_next;
  assign o_pc_write    = w_pc_write;
  assign o_mem_req     = (r_state == ST_REQ);
  assign o_mem_addr    = (r_state == ST_REQ) ? i_pc_cur : {PC_W{1'b0}};
  assign o_instr_out   = r_instr;
  assign o_instr_valid = r_valid;
  assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer: a PC register model plus scoreboard
// queues for PC writes, fetch addresses and accepted instructions.
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc_cur;
  logic [15:0] pc_next;
  logic        pc_write;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic        halt = 1'b0;
  logic        fetch_fault;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] q_pcw[$];
  logic [15:0] q_addr[$];
  logic [15:0] q_instr[$];

  instr_fetch_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .i_pc_cur          (pc_cur),
    .o_pc_next         (pc_next),
    .o_pc_write        (pc_write),
    .o_mem_req         (mem_req),
    .o_mem_addr        (mem_addr),
    .i_mem_ack         (mem_ack),
    .i_mem_rdata       (mem_rdata),
    .o_instr_out       (instr_out),
    .o_instr_valid     (instr_valid),
    .i_instr_ready     (instr_ready),
    .i_redirect        (redirect),
    .i_redirect_target (redirect_target),
    .i_halt            (halt),
    .o_fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  // PC register model.
  always @(posedge clk) begin
    if (reset) pc_cur <= 16'h0000;
    else if (pc_write) pc_cur <= pc_next;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle sampling of DUT outputs against the scoreboard queues.
  logic        p_req = 1'b0, p_ack = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0;
  logic [15:0] p_addr = 16'h0000, p_out = 16'h0000;
  logic [15:0] e;
  always @(negedge clk) begin
    if (reset) begin
      p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_redir = 1'b0;
    end else begin
      if (pc_write) begin
        if (q_pcw.size() == 0) check("pc_write_unexpected", 32'(pc_write), 32'd0);
        else begin e = q_pcw.pop_front(); check("pc_next", 32'(pc_next), 32'(e)); end
      end
      if (mem_req && !(p_req && !p_ack)) begin
        if (q_addr.size() == 0) check("mem_req_unexpected", 32'(mem_req), 32'd0);
        else begin e = q_addr.pop_front(); check("mem_addr", 32'(mem_addr), 32'(e)); end
      end else if (mem_req) begin
        check("mem_addr_stable", 32'(mem_addr), 32'(p_addr));
      end
      if (p_valid && !p_ready && !p_redir) begin
        check("valid_held", 32'(instr_valid), 32'd1);
        check("instr_stable", 32'(instr_out), 32'(p_out));
      end
      if (instr_valid && instr_ready) begin
        if (q_instr.size() == 0) check("instr_unexpected", 32'(instr_out), 32'hFFFF_FFFF);
        else begin e = q_instr.pop_front(); check("instr_out", 32'(instr_out), 32'(e)); end
      end
      p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr;
      p_valid = instr_valid; p_out = instr_out; p_ready = instr_ready; p_redir = redirect;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40; i++) begin
      if (mem_req) break;
      tick();
    end
    check("wait_req_timeout", 32'(mem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset: outputs quiet even with a redirect pending.
    redirect = 1'b1; redirect_target = 16'h0ABC;
    repeat (3) tick();
    check("rst_pc_write", 32'(pc_write), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr_out), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    redirect = 1'b0;

    // 1: first fetch at 0, ack one cycle after request.
    q_addr.push_back(16'h0000); q_pcw.push_back(16'h0002); q_instr.push_back(16'h1234);
    q_addr.push_back(16'h0002);
    reset = 1'b0;
    wait_req();
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_instr", 32'(instr_out), 32'h1234);

    // 2: decode stalls for 5 cycles, then accepts.
    for (int i = 0; i < 5; i++) begin
      check("t2_no_req", 32'(mem_req), 32'd0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // 3: fetch at 2, then redirect to 0040 while held.
    mem_ack = 1'b1; mem_rdata = 16'h5678; q_pcw.push_back(16'h0004);
    tick();
    mem_ack = 1'b0;
    check("t3_hold_valid", 32'(instr_valid), 32'd1);
    redirect = 1'b1; redirect_target = 16'h0040;
    q_pcw.push_back(16'h0040); q_addr.push_back(16'h0040);
    tick();
    redirect = 1'b0;
    check("t3_valid_drop", 32'(instr_valid), 32'd0);

    // 4: redirect to 0080 before ack, stale DEAD discarded.
    redirect = 1'b1; redirect_target = 16'h0080; q_pcw.push_back(16'h0080);
    tick();
    redirect = 1'b0;
    check("t4_drain_no_req", 32'(mem_req), 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hDEAD; q_addr.push_back(16'h0080);
    tick();
    mem_ack = 1'b0;
    check("t4_no_dead", 32'(instr_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF; instr_ready = 1'b1;
    q_pcw.push_back(16'h0082); q_instr.push_back(16'hBEEF);
    tick();
    mem_ack = 1'b0; halt = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("halt_no_req", 32'(mem_req), 32'd0);
      tick();
    end

    // 6: wrap from FFFE, then ack+redirect in the same cycle.
    redirect = 1'b1; redirect_target = 16'hFFFE; q_pcw.push_back(16'hFFFE);
    tick();
    redirect = 1'b0; halt = 1'b0; q_addr.push_back(16'hFFFE);
    wait_req();
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    q_pcw.push_back(16'h0000); q_instr.push_back(16'h1111); q_addr.push_back(16'h0000);
    tick();
    mem_ack = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h2222; redirect = 1'b1; redirect_target = 16'h0100;
    q_pcw.push_back(16'h0100); q_addr.push_back(16'h0100);
    tick();
    mem_ack = 1'b0; redirect = 1'b0;
    check("t6_ack_dropped", 32'(instr_valid), 32'd0);

    // 5: no ack for 15 cycles -> sticky fault.
    repeat (14) tick();
    check("t5_no_fault_yet", 32'(fetch_fault), 32'd0);
    check("t5_still_req", 32'(mem_req), 32'd1);
    tick();
    check("t5_fault", 32'(fetch_fault), 32'd1);
    check("t5_req_drop", 32'(mem_req), 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_idle", 32'(mem_req), 32'd0);
      check("t5_sticky", 32'(fetch_fault), 32'd1);
      tick();
    end
    reset = 1'b1;
    repeat (2) tick();
    check("t5_fault_cleared", 32'(fetch_fault), 32'd0);

    // Reset mid-request; a later ack while idle is ignored.
    q_addr.push_back(16'h0000); q_addr.push_back(16'h0000);
    reset = 1'b0;
    wait_req();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
    check("rst_mid_idle", 32'(mem_req), 32'd0);
    tick();
    mem_ack = 1'b0;
    wait_req();
    mem_ack = 1'b1; mem_rdata = 16'h3333; instr_ready = 1'b1; halt = 1'b1;
    q_pcw.push_back(16'h0002); q_instr.push_back(16'h3333);
    tick();
    mem_ack = 1'b0;
    repeat (3) tick();

    check("q_pcw_empty", 32'(q_pcw.size()), 32'd0);
    check("q_addr_empty", 32'(q_addr.size()), 32'd0);
    check("q_instr_empty", 32'(q_instr.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
